// File: rtl/clk_lock_supervisor.sv
// ----------------------------------------------------------------------------
// clk_lock_supervisor
//
// Consumer-side supervisor for a DCM stage. The block:
//   - pulses the DCM reset,
//   - waits for LOCKED,
//   - requires LOCKED to stay high for a settle window before it raises READY,
//   - retries failed lock attempts a bounded number of times before FAIL,
//   - re-initialises the DCM when lock is lost while READY.
//
// Optional build macro: CLK_SUPERVISOR_STATUS_EN
//   When defined, synchronised STATUS[1] (CLKIN stopped) or STATUS[2]
//   (CLKFX stopped) is treated as loss of lock in SETTLE and READY.
//   When undefined, the STATUS port is present but ignored, and no STATUS
//   synchroniser is built.
//
// All outputs are flops loaded from the next-state decode, so they line up
// with the current state without any combinational path to the pins.
// ----------------------------------------------------------------------------
module clk_lock_supervisor #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             locked_i,
  input  logic [7:0]       status_i,
  input  logic             restart_i,
  output logic             dcm_rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  // --------------------------------------------------------------------------
  // Shared timer sizing: it must be able to hold the largest terminal count
  // used by any state.
  // --------------------------------------------------------------------------
  localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  // Terminal counts, pre-sized to the timer width.
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // FSM encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_RST_ASSERT = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_SETTLE     = 3'd2;
  localparam logic [2:0] ST_READY      = 3'd3;
  localparam logic [2:0] ST_FAIL       = 3'd4;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Saturating increment for the loss counter: it must never wrap back to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,   state_d;
  logic [TW-1:0]    timer_q,   timer_d;
  logic [CNT_W-1:0] retry_q,   retry_d;
  logic [CNT_W-1:0] loss_q,    loss_d;
  logic             dcm_rst_q;
  logic             ready_q;
  logic             fail_q;

  // Synchroniser stages for LOCKED.
  logic             lock_meta_q;
  logic             lock_sync_q;

  // Qualified lock views used by the FSM.
  logic             lk_s;        // synced LOCKED only
  logic             lk_run_s;    // synced LOCKED, optionally masked by STATUS
  logic             clk_stop_s;  // synced "clock stopped" indication
  logic             retry_ok_s;  // another attempt is still allowed
  logic             unused_status_s;

  // Bring the asynchronous LOCKED into the CLK domain through two flops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= locked_i;
      lock_sync_q <= lock_meta_q;
    end
  end

`ifdef CLK_SUPERVISOR_STATUS_EN
  // STATUS[2:1] synchroniser; bit 0 of the pair is STATUS[1], bit 1 is STATUS[2].
  logic [1:0] st_meta_q;
  logic [1:0] st_sync_q;

  // Bring the asynchronous STATUS clock-stopped flags into the CLK domain.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st_meta_q <= 2'b00;
      st_sync_q <= 2'b00;
    end else begin
      st_meta_q <= status_i[2:1];
      st_sync_q <= st_meta_q;
    end
  end

  assign clk_stop_s      = |st_sync_q;
  assign unused_status_s = ^{status_i[7:3], status_i[0]};
`else
  // STATUS is ignored in this build; the port remains for pin compatibility.
  assign clk_stop_s      = 1'b0;
  assign unused_status_s = ^status_i;
`endif

  assign lk_s       = lock_sync_q;
  assign lk_run_s   = lock_sync_q & ~clk_stop_s;
  assign retry_ok_s = (retry_q < RETRY_LIMIT);

  // Next-state, timer and counter logic for the supervisor FSM.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart_i) begin
      // RESTART wins over every other transition, but a lock loss seen in
      // READY during the same cycle is still recorded.
      state_d = ST_RST_ASSERT;
      timer_d = '0;
      retry_d = '0;
      if ((state_q == ST_READY) && !lk_run_s) begin
        loss_d = sat_inc(loss_q);
      end else begin
        loss_d = loss_q;
      end
    end else begin
      case (state_q)
        ST_RST_ASSERT: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = ST_SETTLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            // Lock timeout: retry or give up.
            timer_d = '0;
            if (retry_ok_s) begin
              retry_d = retry_q + CNT_ONE;
              state_d = ST_RST_ASSERT;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_SETTLE: begin
          if (!lk_run_s) begin
            // Lock did not hold through the settle window: retry or give up.
            timer_d = '0;
            if (retry_ok_s) begin
              retry_d = retry_q + CNT_ONE;
              state_d = ST_RST_ASSERT;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (timer_q == SETTLE_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_READY: begin
          if (!lk_run_s) begin
            // Run-time loss of lock: count it and re-initialise the DCM.
            state_d = ST_RST_ASSERT;
            timer_d = '0;
            loss_d  = sat_inc(loss_q);
          end else begin
            timer_d = '0;
          end
        end

        ST_FAIL: begin
          // Parked until RESTART or reset.
          state_d = ST_FAIL;
          timer_d = '0;
        end

        default: begin
          // Unreachable encodings recover through a fresh DCM reset.
          state_d = ST_RST_ASSERT;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RST_ASSERT;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      dcm_rst_q <= (state_d == ST_RST_ASSERT);
      ready_q   <= (state_d == ST_READY);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_clk_lock_supervisor
//
// Directed bench for clk_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=100,
// SETTLE_CYCLES=16, MAX_RETRY=2, CNT_W=8. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, away from the edge.
// Expected cycle counts are worked out by hand from the 2-cycle LOCKED lag.
// ----------------------------------------------------------------------------
module tb_clk_lock_supervisor;

  localparam int BOUND = 1000;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic [7:0] status;
  logic       restart;
  logic       dcm_rst;
  logic       ready;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  int total;
  int passed;
  int failed;

  clk_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .SETTLE_CYCLES(16),
    .MAX_RETRY    (2),
    .CNT_W        (8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .locked_i   (locked),
    .status_i   (status),
    .restart_i  (restart),
    .dcm_rst_o  (dcm_rst),
    .ready_o    (ready),
    .fail_o     (fail),
    .retry_cnt_o(retry_cnt),
    .loss_cnt_o (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles for which dcm_rst stays high, starting at the current sample.
  task automatic count_dcm_high(output int n);
    n = 0;
    while (dcm_rst === 1'b1 && n < BOUND) begin
      n++;
      step();
    end
  endtask

  // Cycles until the selected output goes high: 0=ready, 1=dcm_rst, 2=fail.
  task automatic wait_high(input int which, output int n);
    logic v;
    n = 0;
    v = (which == 0) ? ready : ((which == 1) ? dcm_rst : fail);
    while (v !== 1'b1 && n < BOUND) begin
      step();
      n++;
      v = (which == 0) ? ready : ((which == 1) ? dcm_rst : fail);
    end
  endtask

  initial begin
    int n;
    int exp_loss;
    logic seen_ready;

    total    = 0;
    passed   = 0;
    failed   = 0;
    rst_n    = 1'b0;
    locked   = 1'b0;
    status   = 8'h00;
    restart  = 1'b0;

    // ---- Reset ----
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_dcm_rst", 32'(dcm_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_loss", 32'(loss_cnt), 32'd0);

    // ---- 1: first lock, LOCKED rises at cycle 10 ----
    count_dcm_high(n);
    check("t1_dcm_pulse", 32'(n), 32'd4);
    repeat (6) step();
    locked = 1'b1;
    repeat (18) step();
    check("t1_ready_early", 32'(ready), 32'd0);
    step();
    check("t1_ready_at_19", 32'(ready), 32'd1);
    check("t1_retry", 32'(retry_cnt), 32'd0);
    check("t1_dcm_low", 32'(dcm_rst), 32'd0);

    // ---- 3: 3-cycle lock drop while READY ----
    locked = 1'b0;
    repeat (2) step();
    check("t3_ready_hold", 32'(ready), 32'd1);
    step();
    locked = 1'b1;
    check("t3_ready_drop", 32'(ready), 32'd0);
    check("t3_loss", 32'(loss_cnt), 32'd1);
    count_dcm_high(n);
    check("t3_dcm_pulse", 32'(n), 32'd4);
    wait_high(0, n);
    check("t3_relock_cycles", 32'(n), 32'd17);

    // ---- 2: LOCKED held low, retries exhausted ----
    locked = 1'b0;
    repeat (3) step();
    check("t2_loss", 32'(loss_cnt), 32'd2);
    count_dcm_high(n);
    check("t2_pulse0", 32'(n), 32'd4);
    wait_high(1, n);
    check("t2_gap1", 32'(n), 32'd100);
    check("t2_retry1", 32'(retry_cnt), 32'd1);
    count_dcm_high(n);
    check("t2_pulse1", 32'(n), 32'd4);
    wait_high(1, n);
    check("t2_gap2", 32'(n), 32'd100);
    check("t2_retry2", 32'(retry_cnt), 32'd2);
    count_dcm_high(n);
    check("t2_pulse2", 32'(n), 32'd4);
    wait_high(2, n);
    check("t2_fail_cycles", 32'(n), 32'd100);
    check("t2_fail_retry", 32'(retry_cnt), 32'd2);
    check("t2_fail_dcm", 32'(dcm_rst), 32'd0);
    repeat (20) step();
    check("t2_fail_held", 32'(fail), 32'd1);
    check("t2_fail_dcm_held", 32'(dcm_rst), 32'd0);
    check("t2_fail_ready", 32'(ready), 32'd0);

    // ---- 5: RESTART out of FAIL ----
    restart = 1'b1;
    step();
    restart = 1'b0;
    locked  = 1'b1;
    check("t5_fail_clr", 32'(fail), 32'd0);
    check("t5_retry_clr", 32'(retry_cnt), 32'd0);
    check("t5_dcm_set", 32'(dcm_rst), 32'd1);
    count_dcm_high(n);
    check("t5_dcm_pulse", 32'(n), 32'd4);
    wait_high(0, n);
    check("t5_relock_cycles", 32'(n), 32'd17);

    // ---- 5b: RESTART in the same cycle as a READY loss ----
    locked = 1'b0;
    repeat (2) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    locked  = 1'b1;
    check("t5b_loss", 32'(loss_cnt), 32'd3);
    check("t5b_ready", 32'(ready), 32'd0);
    check("t5b_dcm", 32'(dcm_rst), 32'd1);

    // ---- 4: LOCKED drops at settle count 10 ----
    count_dcm_high(n);
    check("t4_dcm_pulse", 32'(n), 32'd4);
    seen_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      seen_ready = seen_ready | ready;
    end
    locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen_ready = seen_ready | ready;
    end
    check("t4_no_ready", 32'(seen_ready), 32'd0);
    check("t4_retry", 32'(retry_cnt), 32'd1);
    check("t4_dcm", 32'(dcm_rst), 32'd1);
    locked = 1'b1;
    count_dcm_high(n);
    check("t4_dcm_pulse2", 32'(n), 32'd4);
    wait_high(0, n);
    check("t4_relock_cycles", 32'(n), 32'd17);
    check("t4_retry_clr", 32'(retry_cnt), 32'd0);

    // ---- 6a: STATUS[1] while READY ----
    exp_loss = 3;
    status = 8'h02;
    repeat (3) step();
`ifdef CLK_SUPERVISOR_STATUS_EN
    exp_loss = 4;
    check("t6_status_ready", 32'(ready), 32'd0);
`else
    check("t6_status_ready", 32'(ready), 32'd1);
`endif
    check("t6_status_loss", 32'(loss_cnt), 32'(exp_loss));
    status = 8'h00;
    wait_high(0, n);
    check("t6_status_recover", 32'(ready), 32'd1);

    // ---- 6b: 256 forced losses, saturation at 255 ----
    for (int i = 0; i < 256; i++) begin
      locked = 1'b0;
      repeat (3) step();
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
      check("t6_loss_step", 32'(loss_cnt), 32'(exp_loss));
      locked = 1'b1;
      wait_high(0, n);
      check("t6_loss_relock", 32'(n), 32'd21);
    end
    check("t6_loss_sat", 32'(loss_cnt), 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
